// File: rtl/sa_tile_loader.sv
// sa_tile_loader: host-side sequencer for a 4x4 systolic array tile.
// Loads four A rows and four B rows from a word-addressed scratchpad,
// releases the array from reset, waits (with watchdog) for completion,
// captures the four C rows and writes the 16 result words back.
module sa_tile_loader #(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 32,
    parameter int DATAC_BITS = 128,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_BITS-1:0]  base_a,
    input  logic [ADDR_BITS-1:0]  base_b,
    input  logic [ADDR_BITS-1:0]  base_c,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  mem_rd_en,
    output logic [ADDR_BITS-1:0]  mem_rd_addr,
    input  logic [DATA_BITS-1:0]  mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_BITS-1:0]  mem_wr_addr,
    output logic [DATA_BITS-1:0]  mem_wr_data,
    output logic                  sa_rst_n,
    input  logic                  sa_done,
    output logic [DATA_BITS-1:0]  local_buffer_A0,
    output logic [DATA_BITS-1:0]  local_buffer_A1,
    output logic [DATA_BITS-1:0]  local_buffer_A2,
    output logic [DATA_BITS-1:0]  local_buffer_A3,
    output logic [DATA_BITS-1:0]  local_buffer_B0,
    output logic [DATA_BITS-1:0]  local_buffer_B1,
    output logic [DATA_BITS-1:0]  local_buffer_B2,
    output logic [DATA_BITS-1:0]  local_buffer_B3,
    input  logic [DATAC_BITS-1:0] local_buffer_C0,
    input  logic [DATAC_BITS-1:0] local_buffer_C1,
    input  logic [DATAC_BITS-1:0] local_buffer_C2,
    input  logic [DATAC_BITS-1:0] local_buffer_C3
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_WAIT, S_STORE, S_DONE
    } state_t;

    // Last watchdog value before the abort fires (counter starts at 0).
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t                 state_reg, state_next;
    logic [3:0]             idx_reg, idx_next;
    logic [7:0]             wd_reg, wd_next;
    logic                   error_reg, error_next;
    logic [ADDR_BITS-1:0]   base_a_reg, base_b_reg, base_c_reg;
    logic                   rd_pend_reg;
    logic [2:0]             rd_idx_reg;
    logic [DATA_BITS-1:0]   a_reg [4];
    logic [DATA_BITS-1:0]   b_reg [4];
    logic [DATAC_BITS-1:0]  c_reg [4];
    logic [DATAC_BITS-1:0]  c_in  [4];
    logic [DATA_BITS-1:0]   c_word [16];
    logic                   accept;
    logic                   c_capture;

    assign accept    = (state_reg == S_IDLE) && start;
    assign c_capture = (state_reg == S_WAIT) && sa_done;

    assign c_in[0] = local_buffer_C0;
    assign c_in[1] = local_buffer_C1;
    assign c_in[2] = local_buffer_C2;
    assign c_in[3] = local_buffer_C3;

    assign local_buffer_A0 = a_reg[0];
    assign local_buffer_A1 = a_reg[1];
    assign local_buffer_A2 = a_reg[2];
    assign local_buffer_A3 = a_reg[3];
    assign local_buffer_B0 = b_reg[0];
    assign local_buffer_B1 = b_reg[1];
    assign local_buffer_B2 = b_reg[2];
    assign local_buffer_B3 = b_reg[3];
    assign error           = error_reg;

    // FSM state, step index, watchdog and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            wd_reg    <= '0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            wd_reg    <= wd_next;
            error_reg <= error_next;
        end
    end

    // Tile base addresses are frozen for the whole operation on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_a_reg <= '0;
            base_b_reg <= '0;
            base_c_reg <= '0;
        end else if (accept) begin
            base_a_reg <= base_a;
            base_b_reg <= base_b;
            base_c_reg <= base_c;
        end
    end

    // Remember which row each read targets; the data returns one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_reg <= 1'b0;
            rd_idx_reg  <= '0;
        end else begin
            rd_pend_reg <= mem_rd_en;
            rd_idx_reg  <= idx_reg[2:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rows
            // A row gi is filled by read slot gi; held until the next load.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    a_reg[gi] <= '0;
                else if (rd_pend_reg && rd_idx_reg == 3'(gi))
                    a_reg[gi] <= mem_rd_data;
            end

            // B row gi is filled by read slot gi+4.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    b_reg[gi] <= '0;
                else if (rd_pend_reg && rd_idx_reg == 3'(gi + 4))
                    b_reg[gi] <= mem_rd_data;
            end

            // C row gi is sampled in the same cycle the array reports done.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    c_reg[gi] <= '0;
                else if (c_capture)
                    c_reg[gi] <= c_in[gi];
            end
        end

        // Flatten C into 16 write words; word 0 of a row is its top slice.
        for (gi = 0; gi < 16; gi++) begin : g_words
            assign c_word[gi] = c_reg[gi / 4][DATAC_BITS - 1 - DATA_BITS * (gi % 4) -: DATA_BITS];
        end
    endgenerate

    // Next-state logic and all strobes/addresses decoded from the current state.
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        wd_next     = wd_reg;
        error_next  = error_reg;
        busy        = (state_reg != S_IDLE);
        done        = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        sa_rst_n    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    error_next = 1'b0;
                    idx_next   = '0;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                // Slots 0..7 issue reads; slot 8 only absorbs the last returning word.
                if (!idx_reg[3]) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = (idx_reg[2] ? base_b_reg : base_a_reg)
                                  + ADDR_BITS'(idx_reg[1:0]);
                    idx_next    = idx_reg + 4'd1;
                end else begin
                    idx_next   = '0;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                sa_rst_n   = 1'b1;
                wd_next    = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                sa_rst_n = 1'b1;
                if (sa_done) begin
                    idx_next   = '0;
                    state_next = S_STORE;
                end else if (wd_reg == WD_LAST) begin
                    error_next = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    wd_next = wd_reg + 8'd1;
                end
            end
            S_STORE: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = base_c_reg + ADDR_BITS'(idx_reg);
                mem_wr_data = c_word[idx_reg];
                if (idx_reg == 4'd15)
                    state_next = S_DONE;
                else
                    idx_next = idx_reg + 4'd1;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sa_tile_loader.sv
// Testbench for sa_tile_loader: scratchpad model, behavioural 4x4 array model,
// scoreboard queues for expected reads/writes and a negedge monitor.
module tb_sa_tile_loader;

    localparam int TIMEOUT = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  base_a = '0, base_b = '0, base_c = '0;
    logic         busy, done, error;
    logic         mem_rd_en, mem_wr_en;
    logic [15:0]  mem_rd_addr, mem_wr_addr;
    logic [31:0]  mem_rd_data = '0;
    logic [31:0]  mem_wr_data;
    logic         sa_rst_n;
    logic         sa_done = 1'b0;
    logic [31:0]  local_buffer_A0, local_buffer_A1, local_buffer_A2, local_buffer_A3;
    logic [31:0]  local_buffer_B0, local_buffer_B1, local_buffer_B2, local_buffer_B3;
    logic [127:0] lc0 = '0, lc1 = '0, lc2 = '0, lc3 = '0;

    always #5 clk = ~clk;

    sa_tile_loader #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .base_a(base_a), .base_b(base_b), .base_c(base_c),
        .busy(busy), .done(done), .error(error),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .sa_rst_n(sa_rst_n), .sa_done(sa_done),
        .local_buffer_A0(local_buffer_A0), .local_buffer_A1(local_buffer_A1),
        .local_buffer_A2(local_buffer_A2), .local_buffer_A3(local_buffer_A3),
        .local_buffer_B0(local_buffer_B0), .local_buffer_B1(local_buffer_B1),
        .local_buffer_B2(local_buffer_B2), .local_buffer_B3(local_buffer_B3),
        .local_buffer_C0(lc0), .local_buffer_C1(lc1),
        .local_buffer_C2(lc2), .local_buffer_C3(lc3)
    );

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    logic [15:0] exp_rd_q[$];
    wr_t         exp_wr_q[$];
    logic [31:0] tile_a[4], tile_b[4];
    logic [31:0] exp_a[4], exp_b[4];
    logic [31:0] mem [0:65535];
    int          wr_seen = 0, done_seen = 0, hi_cnt = 0;
    int          sa_n = 1;
    bit          sa_never = 1'b0;
    int          run_cnt = 0;
    logic        sa_prev = 1'b0;
    logic [31:0] la[4], lb[4];

    assign la[0] = local_buffer_A0;
    assign la[1] = local_buffer_A1;
    assign la[2] = local_buffer_A2;
    assign la[3] = local_buffer_A3;
    assign lb[0] = local_buffer_B0;
    assign lb[1] = local_buffer_B1;
    assign lb[2] = local_buffer_B2;
    assign lb[3] = local_buffer_B3;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic bad_event(input string nm);
        total++;
        bad++;
        $display("FAIL %s: event occurred with nothing expected", nm);
    endtask

    // Element j of (A row) x B: 8-bit elements, element 0 in the top byte.
    function automatic logic [31:0] dot(input logic [31:0] arow, input logic [31:0] b0,
                                        input logic [31:0] b1, input logic [31:0] b2,
                                        input logic [31:0] b3, input int j);
        logic [31:0] bk[4];
        logic [31:0] s;
        logic [7:0]  x, y;
        bk[0] = b0; bk[1] = b1; bk[2] = b2; bk[3] = b3;
        s = '0;
        for (int k = 0; k < 4; k++) begin
            x = arow[31 - 8 * k -: 8];
            y = bk[k][31 - 8 * j -: 8];
            s = s + {24'b0, x} * {24'b0, y};
        end
        return s;
    endfunction

    function automatic logic [127:0] row_c(input logic [31:0] arow);
        return {dot(arow, lb[0], lb[1], lb[2], lb[3], 0), dot(arow, lb[0], lb[1], lb[2], lb[3], 1),
                dot(arow, lb[0], lb[1], lb[2], lb[3], 2), dot(arow, lb[0], lb[1], lb[2], lb[3], 3)};
    endfunction

    // Scratchpad: registered read, one cycle latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    // Array model: computes A x B from the presented rows, reports done
    // on the sa_n-th cycle after the release cycle (unless told never to).
    always @(negedge clk) begin
        if (!sa_rst_n) begin
            run_cnt = 0;
            sa_done = 1'b0;
        end else begin
            run_cnt++;
            sa_done = !sa_never && (run_cnt == sa_n + 1);
        end
        lc0 = row_c(la[0]);
        lc1 = row_c(la[1]);
        lc2 = row_c(la[2]);
        lc3 = row_c(la[3]);
    end

    // Monitor: pops the scoreboard on every strobe, checks A/B at release.
    always @(negedge clk) begin
        logic [15:0] ea;
        wr_t         ew;
        if (!rst_n) begin
            sa_prev = 1'b0;
        end else begin
            if (mem_rd_en && mem_wr_en) bad_event("rd_wr_same_cycle");
            if (mem_rd_en) begin
                if (exp_rd_q.size() == 0) bad_event("rd_unexpected");
                else begin
                    ea = exp_rd_q.pop_front();
                    chk("rd_addr", 128'(mem_rd_addr), 128'(ea));
                end
            end
            if (mem_wr_en) begin
                wr_seen++;
                if (exp_wr_q.size() == 0) bad_event("wr_unexpected");
                else begin
                    ew = exp_wr_q.pop_front();
                    chk("wr_addr", 128'(mem_wr_addr), 128'(ew.addr));
                    chk("wr_data", 128'(mem_wr_data), 128'(ew.data));
                    $display("write addr=%04h data=%08h", mem_wr_addr, mem_wr_data);
                end
            end
            if (done) done_seen++;
            if (sa_rst_n) hi_cnt++;
            if (sa_rst_n && !sa_prev) begin
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("release_A%0d", k), 128'(la[k]), 128'(exp_a[k]));
                    chk($sformatf("release_B%0d", k), 128'(lb[k]), 128'(exp_b[k]));
                end
            end
            sa_prev = sa_rst_n;
        end
    end

    // Load tiles into the scratchpad and queue the expected bus traffic.
    task automatic prep(input logic [15:0] ba, input logic [15:0] bb,
                        input logic [15:0] bc, input bit never);
        logic [15:0] ad;
        for (int k = 0; k < 4; k++) begin
            ad = ba + 16'(k); mem[ad] = tile_a[k]; exp_rd_q.push_back(ad);
            exp_a[k] = tile_a[k];
        end
        for (int k = 0; k < 4; k++) begin
            ad = bb + 16'(k); mem[ad] = tile_b[k]; exp_rd_q.push_back(ad);
            exp_b[k] = tile_b[k];
        end
        if (!never) begin
            for (int w = 0; w < 16; w++) begin
                exp_wr_q.push_back('{addr: bc + 16'(w),
                    data: dot(tile_a[w / 4], tile_b[0], tile_b[1], tile_b[2], tile_b[3], w % 4)});
            end
        end
    endtask

    task automatic run_tile(input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc,
                            input int n, input bit never, input bit poke);
        int cyc, done0, wr0;
        bit fin, poked;
        prep(ba, bb, bc, never);
        sa_n = n; sa_never = never;
        done0 = done_seen; wr0 = wr_seen;
        @(negedge clk);
        hi_cnt = 0;
        base_a = ba; base_b = bb; base_c = bc; start = 1'b1;
        cyc = 0; fin = 1'b0; poked = 1'b0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("busy_after_start", 128'(busy), 128'(1));
                chk("error_cleared", 128'(error), 128'(0));
                base_a = 16'($urandom); base_b = 16'($urandom); base_c = 16'($urandom);
            end
            if (poke && !poked && sa_rst_n && cyc > 12) begin
                start = 1'b1; poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                fin = 1'b1;
                chk("latency", 128'(cyc + 1), 128'(1 + 9 + 1 + n + 16 + 1));
            end
            if (never && cyc > 1 && !busy) begin
                fin = 1'b1;
                chk("timeout_cycles", 128'(cyc), 128'(1 + 9 + 1 + TIMEOUT));
                chk("timeout_error", 128'(error), 128'(1));
                chk("timeout_sa_rst_n", 128'(sa_rst_n), 128'(0));
                chk("timeout_release_len", 128'(hi_cnt), 128'(TIMEOUT + 1));
            end
        end
        start = 1'b0;
        if (!fin) bad_event("wait_for_completion_expired");
        repeat (3) @(negedge clk);
        chk("done_pulses", 128'(done_seen - done0), 128'(never ? 0 : 1));
        chk("write_count", 128'(wr_seen - wr0), 128'(never ? 0 : 16));
        chk("busy_idle", 128'(busy), 128'(0));
        chk("rd_queue_empty", 128'(exp_rd_q.size()), 128'(0));
        chk("wr_queue_empty", 128'(exp_wr_q.size()), 128'(0));
        $display("tile a=%04h b=%04h c=%04h n=%0d never=%0d poke=%0d cycles=%0d",
                 ba, bb, bc, n, never, poke, cyc);
    endtask

    task automatic run_abort(input logic [15:0] ba, input logic [15:0] bb,
                             input logic [15:0] bc, input int n);
        int wr0, guard;
        prep(ba, bb, bc, 1'b0);
        sa_n = n; sa_never = 1'b0;
        wr0 = wr_seen;
        @(negedge clk);
        base_a = ba; base_b = bb; base_c = bc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (wr_seen < wr0 + 5 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        if (wr_seen < wr0 + 5) bad_event("abort_wait_expired");
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_wr_en", 128'(mem_wr_en), 128'(0));
        chk("abort_rd_en", 128'(mem_rd_en), 128'(0));
        chk("abort_sa_rst_n", 128'(sa_rst_n), 128'(0));
        chk("abort_wr_addr", 128'(mem_wr_addr), 128'(0));
        chk("abort_A0", 128'(local_buffer_A0), 128'(0));
        exp_wr_q.delete();
        exp_rd_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_write_count", 128'(wr_seen - wr0), 128'(5));
        $display("abort after 5 writes c=%04h", bc);
    endtask

    initial begin
        logic [15:0] ba;
        #1;
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_done", 128'(done), 128'(0));
        chk("reset_error", 128'(error), 128'(0));
        chk("reset_rd_en", 128'(mem_rd_en), 128'(0));
        chk("reset_wr_en", 128'(mem_wr_en), 128'(0));
        chk("reset_sa_rst_n", 128'(sa_rst_n), 128'(0));
        chk("reset_A0", 128'(local_buffer_A0), 128'(0));
        chk("reset_B3", 128'(local_buffer_B3), 128'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic tile against identity B.
        tile_a[0] = 32'h01020304; tile_a[1] = 32'h05060708;
        tile_a[2] = 32'h090A0B0C; tile_a[3] = 32'h0D0E0F10;
        tile_b[0] = 32'h01000000; tile_b[1] = 32'h00010000;
        tile_b[2] = 32'h00000100; tile_b[3] = 32'h00000001;
        run_tile(16'h0010, 16'h0020, 16'h0040, 5, 1'b0, 1'b0);

        // Watchdog abort, then a fresh start must clear the error.
        for (int k = 0; k < 4; k++) begin tile_a[k] = $urandom; tile_b[k] = $urandom; end
        run_tile(16'h0100, 16'h0200, 16'h0300, 1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin tile_a[k] = $urandom; tile_b[k] = $urandom; end
        run_tile(16'h0400, 16'h0500, 16'h0600, 2, 1'b0, 1'b0);

        // Start while busy is ignored.
        for (int k = 0; k < 4; k++) begin tile_a[k] = $urandom; tile_b[k] = $urandom; end
        run_tile(16'h0700, 16'h0800, 16'h0900, 8, 1'b0, 1'b1);

        // Reset mid-STORE, then a normal run.
        for (int k = 0; k < 4; k++) begin tile_a[k] = $urandom; tile_b[k] = $urandom; end
        run_abort(16'h0A00, 16'h0B00, 16'h0C00, 3);
        for (int k = 0; k < 4; k++) begin tile_a[k] = $urandom; tile_b[k] = $urandom; end
        run_tile(16'h0D00, 16'h0E00, 16'h0F00, 4, 1'b0, 1'b0);

        // Address wrap on both reads and writes.
        for (int k = 0; k < 4; k++) begin tile_a[k] = $urandom; tile_b[k] = $urandom; end
        run_tile(16'hFFFE, 16'h1000, 16'hFFF8, 6, 1'b0, 1'b0);

        // Random tiles, bases and array latencies.
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 4; k++) begin tile_a[k] = $urandom; tile_b[k] = $urandom; end
            ba = 16'($urandom);
            run_tile(ba, ba + 16'h0100, 16'($urandom), int'($urandom_range(1, 20)), 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
